// File: rtl/aclk_controller.sv
// Alarm clock sequencing FSM: keypad entry, alarm view and commit strobes,
// with an inactivity timeout on key entry counted in one_second ticks.
module aclk_controller #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter logic [3:0]  NOKEY     = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       show_alarm,
  output logic       show_new_time,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c
);

  localparam int unsigned CNT_W       = 4;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_S);

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAITED = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             key_valid;
  logic             timeout;
  logic             in_entry;

  // Codes above 9 (including NOKEY) all mean "no key".
  assign key_valid = (key <= 4'd9) && (key != NOKEY);
  assign timeout   = (count_q == TIMEOUT_CNT);
  assign in_entry  = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Inactivity counter: only live while waiting on the keypad, saturating.
  always_comb begin
    count_d = '0;
    if (in_entry) begin
      count_d = count_q;
      if (one_second && !timeout) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Next state and state/input decodes.
  always_comb begin
    state_d       = state_q;
    show_alarm    = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_d = SHOW_ALARM;
        end else if (key_valid) begin
          state_d = KEY_STORED;
        end
      end
      KEY_STORED: begin
        show_new_time = 1'b1;
        shift         = 1'b1;
        state_d       = KEY_WAITED;
      end
      KEY_WAITED: begin
        show_new_time = 1'b1;
        if (timeout) begin
          state_d = SHOW_TIME;
        end else if (!key_valid) begin
          state_d = KEY_ENTRY;
        end
      end
      KEY_ENTRY: begin
        show_new_time = 1'b1;
        load_new_a    = alarm_button;
        load_new_c    = time_button && !alarm_button;
        if (alarm_button || time_button) begin
          state_d = SHOW_TIME;
        end else if (key_valid) begin
          state_d = KEY_STORED;
        end else if (timeout) begin
          state_d = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        show_alarm = 1'b1;
        if (!alarm_button) begin
          state_d = SHOW_TIME;
        end
      end
      default: state_d = SHOW_TIME;
    endcase
  end

endmodule

// File: tb/tb_aclk_controller.sv
// Directed bench for aclk_controller: each task applies per-cycle vectors of
// {key, alarm_button, time_button, one_second} and checks the output decodes.
module tb_aclk_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key;
  logic       show_alarm;
  logic       show_new_time;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic [4:0] outs;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_ALARM = 5'b10000;
  localparam logic [4:0] O_SHIFT = 5'b01100;
  localparam logic [4:0] O_NEW   = 5'b01000;
  localparam logic [4:0] O_LD_A  = 5'b01010;
  localparam logic [4:0] O_LD_C  = 5'b01001;
  localparam logic [3:0] NK      = 4'hA;

  aclk_controller dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .key          (key),
    .show_alarm   (show_alarm),
    .show_new_time(show_new_time),
    .shift        (shift),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c)
  );

  always #5 clock = ~clock;

  assign outs = {show_alarm, show_new_time, shift, load_new_a, load_new_c};

  // Vector layout: [11:8] key, [7] alarm, [6] time, [5] tick, [4:0] expected outs.
  function automatic logic [11:0] v(input logic [3:0] k, input logic a, input logic t,
                                    input logic o, input logic [4:0] e);
    return {k, a, t, o, e};
  endfunction

  task automatic drive(input logic [11:0] vec);
    @(posedge clock);
    #1;
    key          = vec[11:8];
    alarm_button = vec[7];
    time_button  = vec[6];
    one_second   = vec[5];
    #1;
  endtask

  task automatic test_reset;
    logic [11:0] q[$];
    reset = 1'b1; key = NK; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
    #2;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_hold: outs=%b expected=%b", outs, O_IDLE);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_release: outs=%b expected=%b", outs, O_IDLE);
    end
    for (int i = 0; i < 20; i++) begin
      q.push_back(v(NK, 0, 0, 1, O_IDLE));
      q.push_back(v(NK, 0, 0, 0, O_IDLE));
    end
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL reset_idle[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_time_commit;
    logic [11:0] q[$];
    q.push_back(v(4'd3, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd3, 0, 0, 0, O_SHIFT));
    q.push_back(v(4'd3, 0, 0, 0, O_NEW));
    q.push_back(v(4'd3, 0, 0, 0, O_NEW));
    q.push_back(v(4'd3, 0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 1, 0, O_LD_C));
    q.push_back(v(NK,   0, 1, 0, O_IDLE));
    q.push_back(v(NK,   0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL time_commit[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_alarm_commit;
    logic [11:0] q[$];
    q.push_back(v(4'd7, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd7, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   1, 1, 0, O_LD_A));
    q.push_back(v(NK,   0, 0, 0, O_IDLE));
    q.push_back(v(NK,   0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL alarm_commit[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] q[$];
    q.push_back(v(4'd1, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd1, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(4'd2, 0, 0, 0, O_NEW));
    q.push_back(v(4'd2, 0, 0, 0, O_SHIFT));
    q.push_back(v(4'd2, 0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   1, 0, 0, O_LD_A));
    q.push_back(v(NK,   0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL back_to_back[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_timeout;
    logic [11:0] q[$];
    q.push_back(v(4'd5, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd5, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    for (int i = 0; i < 10; i++) begin
      q.push_back(v(NK, 0, 0, 1, O_NEW));
      q.push_back(v(NK, 0, 0, 0, O_NEW));
    end
    q.push_back(v(NK, 0, 0, 0, O_IDLE));
    // Second entry: a key after 9 ticks restarts the count.
    q.push_back(v(4'd5, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd5, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    for (int i = 0; i < 9; i++) begin
      q.push_back(v(NK, 0, 0, 1, O_NEW));
      q.push_back(v(NK, 0, 0, 0, O_NEW));
    end
    q.push_back(v(4'd4, 0, 0, 0, O_NEW));
    q.push_back(v(4'd4, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    for (int i = 0; i < 10; i++) begin
      q.push_back(v(NK, 0, 0, 1, O_NEW));
      q.push_back(v(NK, 0, 0, 0, O_NEW));
    end
    q.push_back(v(NK, 0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL timeout[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_commit_vs_timeout;
    logic [11:0] q[$];
    q.push_back(v(4'd1, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd1, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    for (int i = 0; i < 9; i++) begin
      q.push_back(v(NK, 0, 0, 1, O_NEW));
      q.push_back(v(NK, 0, 0, 0, O_NEW));
    end
    q.push_back(v(NK, 0, 0, 1, O_NEW));
    q.push_back(v(NK, 0, 1, 0, O_LD_C));
    q.push_back(v(NK, 0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL commit_vs_timeout[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_held_key_timeout;
    logic [11:0] q[$];
    q.push_back(v(4'd9, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd9, 0, 0, 0, O_SHIFT));
    for (int i = 0; i < 10; i++) begin
      q.push_back(v(4'd9, 0, 0, 1, O_NEW));
      q.push_back(v(4'd9, 0, 0, 0, O_NEW));
    end
    q.push_back(v(4'd9, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd9, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 1, 0, O_LD_C));
    q.push_back(v(NK,   0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL held_key_timeout[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_alarm_view;
    logic [11:0] q[$];
    q.push_back(v(4'd2, 1, 0, 0, O_IDLE));
    for (int i = 0; i < 7; i++) q.push_back(v(4'd2, 1, 0, 0, O_ALARM));
    q.push_back(v(4'd2, 0, 0, 0, O_ALARM));
    q.push_back(v(4'd2, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd2, 0, 0, 0, O_SHIFT));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 0, 0, O_NEW));
    q.push_back(v(NK,   0, 1, 0, O_LD_C));
    q.push_back(v(NK,   0, 0, 0, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL alarm_view[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
  endtask

  task automatic test_reset_mid_entry;
    logic [11:0] q[$];
    logic [11:0] r[$];
    q.push_back(v(4'd8, 0, 0, 0, O_IDLE));
    q.push_back(v(4'd8, 0, 0, 0, O_SHIFT));
    q.push_back(v(4'd8, 0, 0, 0, O_NEW));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (outs !== q[i][4:0]) begin
        errors++; $display("FAIL reset_mid_pre[%0d]: outs=%b expected=%b", i, outs, q[i][4:0]);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_mid_async: outs=%b expected=%b", outs, O_IDLE);
    end
    key = NK;
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_mid_release: outs=%b expected=%b", outs, O_IDLE);
    end
    r.push_back(v(4'd6, 0, 0, 0, O_IDLE));
    r.push_back(v(4'd6, 0, 0, 0, O_SHIFT));
    r.push_back(v(4'd6, 0, 0, 0, O_NEW));
    r.push_back(v(NK,   0, 0, 0, O_NEW));
    r.push_back(v(NK,   0, 0, 0, O_NEW));
    r.push_back(v(NK,   0, 1, 0, O_LD_C));
    r.push_back(v(NK,   0, 0, 0, O_IDLE));
    foreach (r[i]) begin
      drive(r[i]);
      checks++;
      if (outs !== r[i][4:0]) begin
        errors++; $display("FAIL reset_mid_post[%0d]: outs=%b expected=%b", i, outs, r[i][4:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_time_commit();
    test_alarm_commit();
    test_back_to_back();
    test_timeout();
    test_commit_vs_timeout();
    test_held_key_timeout();
    test_alarm_view();
    test_reset_mid_entry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aclk_controller.md
Name: aclk_controller

Overview:
Main sequencing FSM of the alarm clock. It interprets keypad codes and the alarm/time buttons. It drives the display-select inputs (show_alarm, show_new_time) of the LCD driver, the shift strobe of the key-entry register, and the load strobes of the alarm and current-time registers. A key-entry inactivity timeout, counted in one_second ticks, returns the display to the current time.

Parameters:
TIMEOUT_S, 10, number of one_second ticks of inactivity in key entry before abandoning; legal range 1..15
NOKEY, 4'hA, key code meaning "no key pressed"; codes 0..9 are digits, 4'hB..4'hF are treated as NOKEY

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
one_second  input  1  single-cycle tick, once per second
alarm_button  input  1  level; held to view the alarm, pressed in entry to commit to alarm
time_button  input  1  level; pressed in entry to commit to current time
key  input  4  keypad code, level, held while key is down
show_alarm  output  1  LCD driver select: display alarm time
show_new_time  output  1  LCD driver select: display key-entry value
shift  output  1  one-cycle strobe: shift current key into the key register
load_new_a  output  1  one-cycle strobe: load key register into alarm register
load_new_c  output  1  one-cycle strobe: load key register into current-time counter

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Clock port is clock, reset port is reset.
- Reset state:
  - state=SHOW_TIME, timeout counter=0.
  - All outputs 0 while reset is high and in the first cycle after release.
- key_valid = (key <= 4'd9).
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM (3-bit register).
- SHOW_TIME:
  - alarm_button -> SHOW_ALARM.
  - else key_valid -> KEY_STORED.
  - else stay.
- KEY_STORED: unconditionally -> KEY_WAITED after exactly 1 cycle.
- KEY_WAITED (waiting for key release):
  - timeout -> SHOW_TIME.
  - else !key_valid -> KEY_ENTRY.
  - else stay.
- KEY_ENTRY, priority order:
  - alarm_button -> SHOW_TIME.
  - time_button -> SHOW_TIME.
  - key_valid -> KEY_STORED.
  - timeout -> SHOW_TIME.
  - else stay.
- SHOW_ALARM:
  - stay while alarm_button=1.
  - alarm_button=0 -> SHOW_TIME.
  - keys are ignored.
- Outputs are combinational decodes of the registered state and current inputs:
  - show_alarm = (state==SHOW_ALARM).
  - show_new_time = state in {KEY_STORED, KEY_WAITED, KEY_ENTRY}.
  - shift = (state==KEY_STORED).
  - load_new_a = (state==KEY_ENTRY) & alarm_button.
  - load_new_c = (state==KEY_ENTRY) & time_button & !alarm_button.
- load_new_a and load_new_c are never both 1; alarm_button wins.
- Each load strobe is 1 cycle, because the state leaves KEY_ENTRY on the same edge.
- Timeout counter (4 bits):
  - Cleared to 0 in every cycle where state is not KEY_WAITED and not KEY_ENTRY.
  - In those two states, increments on each one_second=1 and saturates at TIMEOUT_S.
  - It is not cleared on KEY_WAITED->KEY_ENTRY; it is cleared on each new key via KEY_STORED.
  - timeout = (count == TIMEOUT_S).
- Timeout latency: the edge sampling the TIMEOUT_S-th tick sets count=TIMEOUT_S; the next edge moves state to SHOW_TIME, unless a higher-priority event fires first.
- Simultaneous events:
  - alarm_button with a valid key in SHOW_TIME goes to SHOW_ALARM; the key is not stored.
  - time_button with timeout in KEY_ENTRY gives load_new_c; the commit wins.
- A key held in SHOW_ALARM and still held when alarm_button is released:
  - Enter SHOW_TIME first.
  - Then KEY_STORED on the next edge; the key counts as a new press.
- Reset mid-entry: abandons entry immediately, with no shift or load strobes.
- Unused state encodings -> SHOW_TIME on the next edge.

Test Plan:
1. Reset, key=4'hA, no buttons, 20 one_second ticks -> state SHOW_TIME throughout; all outputs 0.
2. Press key=4'd3 for 5 cycles, release to 4'hA, press time_button for 2 cycles:
   - show_new_time=1 from cycle after press.
   - shift=1 exactly 1 cycle.
   - load_new_c=1 exactly 1 cycle after the time_button edge, then show_new_time=0.
3. Enter digit 7, release, press alarm_button and time_button together -> load_new_a=1 for 1 cycle, load_new_c=0.
4. Enter digit 5, release, apply 10 one_second ticks (TIMEOUT_S=10):
   - show_new_time drops 1 cycle after the 10th tick is sampled.
   - no load strobes.
   - A key at tick 9 instead restarts the count.
5. From SHOW_TIME hold alarm_button 8 cycles with key=4'd2 asserted:
   - show_alarm=1 for those cycles, no shift.
   - On release: show_alarm=0, then shift=1 one cycle later.
6. Assert reset asynchronously (mid-clock) while in KEY_WAITED -> all outputs 0 without waiting for a clock edge; after release a new key yields a single shift.
